// File: rtl/sap_core_param.sv
// Parametrised SAP-class accumulator core: internal RAM, host program-load port,
// C/Z flags, conditional jumps, LDI immediate and a valid/ready OUT handshake.
module sap_core_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              halted
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic [2:0] S_F1 = 3'd0;
   localparam logic [2:0] S_F2 = 3'd1;
   localparam logic [2:0] S_EX = 3'd2;
   localparam logic [2:0] S_M  = 3'd3;
   localparam logic [2:0] S_OW = 3'd4;
   localparam logic [2:0] S_H  = 3'd5;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JC  = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [DATA_W-1:0] ram [DEPTH];

   logic [2:0]        state, state_d;
   logic [ADDR_W-1:0] pc, pc_d;
   logic [ADDR_W-1:0] mar, mar_d;
   logic [3:0]        op, op_d;
   logic [ADDR_W-1:0] arg, arg_d;
   logic [DATA_W-1:0] a, a_d;
   logic              c, c_d;
   logic              z, z_d;
   logic [DATA_W-1:0] out_d;
   logic              out_valid_d;
   logic              halted_d;

   logic [DATA_W-1:0] rd_c;
   logic [DATA_W:0]   sum_c;
   logic [DATA_W-1:0] diff_c;
   logic              sta_we_c;
   logic              ram_we_c;
   logic [ADDR_W-1:0] ram_waddr_c;
   logic [DATA_W-1:0] ram_wdata_c;

   assign rd_c   = ram[mar];
   assign sum_c  = {1'b0, a} + {1'b0, rd_c};
   assign diff_c = a - rd_c;

   // Next-state and datapath decode
   always_comb begin
      state_d     = state;
      pc_d        = pc;
      mar_d       = mar;
      op_d        = op;
      arg_d       = arg;
      a_d         = a;
      c_d         = c;
      z_d         = z;
      out_d       = out;
      out_valid_d = out_valid;
      halted_d    = halted;
      sta_we_c    = 1'b0;

      case (state)
         S_F1: begin
            mar_d   = pc;
            state_d = S_F2;
         end
         S_F2: begin
            op_d    = rd_c[DATA_W-1 -: 4];
            arg_d   = rd_c[ADDR_W-1:0];
            pc_d    = pc + ADDR_W'(1);
            state_d = S_EX;
         end
         S_EX: begin
            state_d = S_F1;
            case (op)
               OP_LDA, OP_ADD, OP_SUB: begin
                  mar_d   = arg;
                  state_d = S_M;
               end
               OP_STA: sta_we_c = 1'b1;
               OP_LDI: a_d = DATA_W'(arg);
               OP_JMP: pc_d = arg;
               OP_JC:  if (c) pc_d = arg;
               OP_JZ:  if (z) pc_d = arg;
               OP_OUT: begin
                  out_d       = a;
                  out_valid_d = 1'b1;
                  state_d     = S_OW;
               end
               OP_HLT: begin
                  halted_d = 1'b1;
                  state_d  = S_H;
               end
               default: state_d = S_F1;
            endcase
         end
         S_M: begin
            state_d = S_F1;
            case (op)
               OP_LDA: a_d = rd_c;
               OP_ADD: begin
                  a_d = sum_c[DATA_W-1:0];
                  c_d = sum_c[DATA_W];
                  z_d = (sum_c[DATA_W-1:0] == '0);
               end
               OP_SUB: begin
                  a_d = diff_c;
                  c_d = (a >= rd_c);
                  z_d = (diff_c == '0);
               end
               default: a_d = a;
            endcase
         end
         S_OW: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_F1;
            end
         end
         S_H: state_d = S_H;
         default: state_d = S_F1;
      endcase

      // Host writes only while held in reset or halted; STA never fires under clr
      if (clr || halted) begin
         ram_we_c    = prog_we;
         ram_waddr_c = prog_addr;
         ram_wdata_c = prog_data;
      end else begin
         ram_we_c    = sta_we_c;
         ram_waddr_c = arg;
         ram_wdata_c = a;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= S_F1;
         pc        <= '0;
         mar       <= '0;
         op        <= '0;
         arg       <= '0;
         a         <= '0;
         c         <= 1'b0;
         z         <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         mar       <= mar_d;
         op        <= op_d;
         arg       <= arg_d;
         a         <= a_d;
         c         <= c_d;
         z         <= z_d;
         out       <= out_d;
         out_valid <= out_valid_d;
         halted    <= halted_d;
      end
   end

   // Program RAM is not reset
   always_ff @(posedge clk) begin
      if (ram_we_c) ram[ram_waddr_c] <= ram_wdata_c;
   end

endmodule

// File: tb/tb_sap_core_param.sv
// Directed bench for sap_core_param: arithmetic, branches, handshake backpressure,
// reset in OW/H, host loads, and PC wrap with an ignored mid-run write.
module tb_sap_core_param;

   logic       clk;
   logic       clr;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [7:0] out;
   logic       out_valid;
   logic       out_ready;
   logic       halted;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] img [16];
   logic [7:0] outs [$];
   int         cyc_q [$];

   sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk       (clk),
      .clr       (clr),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] q_at(input int i);
      if (i < outs.size()) return 32'(outs[i]);
      return 32'hDEAD_BEEF;
   endfunction

   task automatic fill_nop();
      for (int i = 0; i < 16; i++) img[i] = 8'h80;
   endtask

   // Hold clr high and write the whole image through the host port
   task automatic load_img();
      clr = 1'b1;
      for (int i = 0; i < 16; i++) begin
         prog_we   = 1'b1;
         prog_addr = 4'(i);
         prog_data = img[i];
         @(posedge clk); #1;
      end
      prog_we = 1'b0;
   endtask

   task automatic run_to_halt(input string tag, input int budget);
      int k;
      k = 0;
      outs.delete();
      while (!halted && k < budget) begin
         @(posedge clk); #1;
         k++;
         if (out_valid) outs.push_back(out);
      end
      check({tag, "_halted"}, 32'(halted), 32'd1);
   endtask

   task automatic load_t1();
      fill_nop();
      img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'hE0; img[3] = 8'hF0;
      img[9] = 8'h10; img[10] = 8'h14;
      load_img();
   endtask

   initial begin
      clr = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; out_ready = 1'b1;

      // Test 1: LDA/ADD/OUT/HLT with exact cycle timing
      load_t1();
      check("rst_out",    32'(out),       32'h0);
      check("rst_ovalid", 32'(out_valid), 32'h0);
      check("rst_halted", 32'(halted),    32'h0);
      check("rst_pc",     32'(dut.pc),    32'h0);
      check("rst_a",      32'(dut.a),     32'h0);
      clr = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 10) check("t1_ov_pre", 32'(out_valid), 32'd0);
         if (cyc == 11) begin
            check("t1_ov",  32'(out_valid), 32'd1);
            check("t1_out", 32'(out),       32'h24);
         end
         if (cyc == 12) check("t1_ov_drop", 32'(out_valid), 32'd0);
         if (cyc == 14) check("t1_nohalt",  32'(halted),    32'd0);
         if (cyc == 15) check("t1_halt",    32'(halted),    32'd1);
      end
      check("t1_out_hold", 32'(out),   32'h24);
      check("t1_c",        32'(dut.c), 32'd0);
      check("t1_z",        32'(dut.z), 32'd0);

      // Test 2: ADD carry then JC taken
      fill_nop();
      img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'h65; img[3] = 8'hF0;
      img[4] = 8'h80; img[5] = 8'hE0; img[6] = 8'hF0;
      img[9] = 8'hF0; img[10] = 8'h20;
      load_img();
      clr = 1'b0;
      run_to_halt("t2", 200);
      check("t2_nout", 32'(outs.size()), 32'd1);
      check("t2_out0", q_at(0), 32'h10);
      check("t2_a",    32'(dut.a), 32'h10);
      check("t2_c",    32'(dut.c), 32'd1);
      check("t2_z",    32'(dut.z), 32'd0);

      // Test 3: countdown with SUB, JZ, JMP
      fill_nop();
      img[0] = 8'h43; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'h75;
      img[4] = 8'h51; img[5] = 8'hF0; img[15] = 8'h01;
      load_img();
      clr = 1'b0;
      run_to_halt("t3", 400);
      check("t3_nout", 32'(outs.size()), 32'd3);
      check("t3_out0", q_at(0), 32'h02);
      check("t3_out1", q_at(1), 32'h01);
      check("t3_out2", q_at(2), 32'h00);
      check("t3_z",    32'(dut.z), 32'd1);
      check("t3_c",    32'(dut.c), 32'd1);

      // Host write is honoured while halted
      prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h4A;
      @(posedge clk); #1;
      prog_we = 1'b0;
      check("t3_hwrite", 32'(dut.ram[0]), 32'h4A);

      // Test 4: backpressure for 5 cycles in OW
      load_t1();
      out_ready = 1'b0;
      clr = 1'b0;
      for (int cyc = 1; cyc <= 21; cyc++) begin
         @(posedge clk); #1;
         if (cyc >= 12 && cyc <= 16) begin
            check($sformatf("t4_ov_c%0d", cyc),  32'(out_valid), 32'd1);
            check($sformatf("t4_out_c%0d", cyc), 32'(out),       32'h24);
            check($sformatf("t4_pc_c%0d", cyc),  32'(dut.pc),    32'd3);
         end
         if (cyc == 16) out_ready = 1'b1;
         if (cyc == 17) check("t4_ov_drop", 32'(out_valid), 32'd0);
         if (cyc == 19) check("t4_nohalt",  32'(halted),    32'd0);
         if (cyc == 20) check("t4_halt",    32'(halted),    32'd1);
      end

      // Test 5: clr while in OW, then clr while in H
      load_t1();
      out_ready = 1'b0;
      clr = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
      check("t5_in_ow", 32'(out_valid), 32'd1);
      clr = 1'b1;
      @(posedge clk); #1;
      check("t5_ow_ov",  32'(out_valid),   32'd0);
      check("t5_ow_out", 32'(out),         32'h0);
      check("t5_ow_pc",  32'(dut.pc),      32'h0);
      check("t5_ow_a",   32'(dut.a),       32'h0);
      check("t5_ram9",   32'(dut.ram[9]),  32'h10);
      clr = 1'b0; out_ready = 1'b1;
      run_to_halt("t5a", 200);
      check("t5a_nout", 32'(outs.size()), 32'd1);
      check("t5a_out0", q_at(0), 32'h24);
      clr = 1'b1;
      @(posedge clk); #1;
      check("t5_h_halted", 32'(halted),    32'd0);
      check("t5_h_out",    32'(out),       32'h0);
      check("t5_h_ov",     32'(out_valid), 32'd0);
      check("t5_h_pc",     32'(dut.pc),    32'h0);
      clr = 1'b0;
      run_to_halt("t5b", 200);
      check("t5b_out0", q_at(0), 32'h24);

      // Test 6: NOP loop with OUT at 1, PC wraps; running host write ignored
      fill_nop();
      img[1] = 8'hE0;
      load_img();
      clr = 1'b0;
      cyc_q.delete();
      for (int cyc = 1; cyc <= 110; cyc++) begin
         @(posedge clk); #1;
         if (out_valid) cyc_q.push_back(cyc);
         if (cyc == 20) begin
            prog_we = 1'b1; prog_addr = 4'h5; prog_data = 8'hF0;
         end
         if (cyc == 21) prog_we = 1'b0;
      end
      check("t6_nout", 32'(cyc_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] got;
         logic [31:0] exp;
         got = (i < cyc_q.size()) ? 32'(cyc_q[i]) : 32'hDEAD_BEEF;
         exp = 32'(6 + 49 * i);
         check($sformatf("t6_outcyc%0d", i), got, exp);
      end
      check("t6_nohalt", 32'(halted),        32'd0);
      check("t6_ram5",   32'(dut.ram[5]),    32'h80);
      check("t6_out",    32'(out),           32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
